// File: rtl/kelly_portfolio.sv
// kelly_portfolio: multi-stock Kelly trader with a per-stock ledger.
// Accepts one tagged price sample per transaction. It majority-votes the
// indicator buy/sell flags and sizes each trade as a Kelly fraction of the
// current holding. The trade is checked against cash and position before the
// ledger is updated, and the portfolio is then revalued one stock per cycle.
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   enable            sample valid, taken when enable && in_ready
//   data_in           {stock_id, price}
//   buy_votes         {RSI_buy, EMA_buy, Momentum_buy}
//   sell_votes        {RSI_sell, EMA_sell, Momentum_sell}
//   in_ready          high only while idle
//   trade_valid       1-cycle pulse when a trade executes
//   trade_side/id/qty/cost  last executed trade (0 = buy, 1 = sell)
//   reject_cnt        buys refused for lack of cash (wraps)
//   cash              current cash
//   equity, pnl       portfolio value and profit vs. initial book
//   equity_valid      1-cycle pulse when equity/pnl are refreshed
module kelly_portfolio #(
    parameter int unsigned N_STOCKS    = 4,
    parameter int unsigned ID_W        = 2,
    parameter int unsigned PRICE_W     = 14,
    parameter int unsigned QTY_W       = 10,
    parameter int unsigned CASH_W      = 24,
    parameter int unsigned EQ_W        = 32,
    parameter int unsigned INIT_CASH   = 25000,
    parameter int unsigned INIT_SHARES = 100,
    parameter int unsigned KELLY_PCT   = 20,
    parameter int unsigned VOTE_TH     = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic [ID_W+PRICE_W-1:0]    data_in,
    input  logic [2:0]                 buy_votes,
    input  logic [2:0]                 sell_votes,
    output logic                       in_ready,
    output logic                       trade_valid,
    output logic                       trade_side,
    output logic [ID_W-1:0]            trade_id,
    output logic [QTY_W-1:0]           trade_qty,
    output logic [QTY_W+PRICE_W-1:0]   trade_cost,
    output logic [7:0]                 reject_cnt,
    output logic [CASH_W-1:0]          cash,
    output logic [EQ_W-1:0]            equity,
    output logic signed [EQ_W-1:0]     pnl,
    output logic                       equity_valid
);

    localparam int unsigned COST_W = QTY_W + PRICE_W;
    // holding * KELLY_PCT needs 7 extra bits for a percentage up to 100
    localparam int unsigned PROD_W = QTY_W + 7;
    localparam int unsigned SUM_W  = ((CASH_W > COST_W) ? CASH_W : COST_W) + 1;
    localparam logic [CASH_W-1:0] CASH_MAX = '1;

    typedef enum logic [1:0] {IDLE, CALC, EXEC, VALUE} state_t;

    state_t state, state_n;
    logic   accept_c, last_c;

    // registered transaction
    logic [ID_W-1:0]    r_id;
    logic [PRICE_W-1:0] r_price;
    logic [1:0]         r_nb, r_ns;

    // decision from CALC, applied in EXEC
    logic               d_trade, d_side, d_rej;
    logic [QTY_W-1:0]   d_qty;
    logic [COST_W-1:0]  d_cost;

    // ledger
    logic [QTY_W-1:0]   holding    [N_STOCKS];
    logic [PRICE_W-1:0] last_price [N_STOCKS];

    // revaluation
    logic [ID_W-1:0]    val_idx;
    logic [EQ_W-1:0]    acc_eq, acc_px;

    function automatic logic [1:0] pop3(input logic [2:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next-state and control strobes
    always_comb begin
        state_n  = state;
        accept_c = 1'b0;
        last_c   = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    accept_c = 1'b1;
                    state_n  = CALC;
                end
            end
            CALC: state_n = EXEC;
            EXEC: state_n = VALUE;
            VALUE: begin
                if (val_idx == ID_W'(N_STOCKS - 1)) begin
                    last_c  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Trade decision: vote, Kelly sizing, cash/position checks
    logic [QTY_W-1:0]  h_c, q_kelly_c, q_c;
    logic [PROD_W-1:0] prod_c, qfull_c;
    logic [COST_W-1:0] cost_c;
    logic [QTY_W:0]    hsum_c;
    logic              buy_v_c, sell_v_c, buy_c, sell_c, trade_c, reject_c;

    always_comb begin
        h_c       = holding[r_id];
        prod_c    = PROD_W'(h_c) * PROD_W'(KELLY_PCT);
        qfull_c   = prod_c / PROD_W'(100);
        q_kelly_c = (qfull_c == '0) ? QTY_W'(1) : QTY_W'(qfull_c);
        buy_v_c   = (r_nb >= 2'(VOTE_TH));
        sell_v_c  = (r_ns >= 2'(VOTE_TH));
        buy_c     = buy_v_c && !sell_v_c;
        sell_c    = sell_v_c && !buy_v_c;
        q_c       = q_kelly_c;
        if (sell_c && (q_kelly_c > h_c)) q_c = h_c;
        cost_c    = COST_W'(q_c) * COST_W'(r_price);
        hsum_c    = {1'b0, h_c} + {1'b0, q_c};
        trade_c   = 1'b0;
        reject_c  = 1'b0;
        if (buy_c) begin
            if (SUM_W'(cost_c) > SUM_W'(cash)) reject_c = 1'b1;
            else if (!hsum_c[QTY_W])            trade_c  = 1'b1;
        end else if (sell_c && (h_c != '0)) begin
            trade_c = 1'b1;
        end
    end

    // Sell proceeds, saturating at the top of the cash register
    logic [SUM_W-1:0]  sell_sum_c;
    logic [CASH_W-1:0] cash_sell_c;

    always_comb begin
        sell_sum_c  = SUM_W'(cash) + SUM_W'(d_cost);
        cash_sell_c = (sell_sum_c > SUM_W'(CASH_MAX)) ? CASH_MAX : CASH_W'(sell_sum_c);
    end

    // Revaluation step for the current stock
    logic [EQ_W-1:0] eq_next_c, px_next_c, eq_total_c, pnl_c;

    always_comb begin
        eq_next_c  = acc_eq + EQ_W'(holding[val_idx]) * EQ_W'(last_price[val_idx]);
        px_next_c  = acc_px + EQ_W'(last_price[val_idx]);
        eq_total_c = EQ_W'(cash) + eq_next_c;
        pnl_c      = eq_total_c - EQ_W'(INIT_CASH) - EQ_W'(INIT_SHARES) * px_next_c;
    end

    // Datapath and ledger
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready     <= 1'b1;
            trade_valid  <= 1'b0;
            trade_side   <= 1'b0;
            trade_id     <= '0;
            trade_qty    <= '0;
            trade_cost   <= '0;
            reject_cnt   <= '0;
            cash         <= CASH_W'(INIT_CASH);
            equity       <= EQ_W'(INIT_CASH);
            pnl          <= '0;
            equity_valid <= 1'b0;
            r_id         <= '0;
            r_price      <= '0;
            r_nb         <= '0;
            r_ns         <= '0;
            d_trade      <= 1'b0;
            d_side       <= 1'b0;
            d_rej        <= 1'b0;
            d_qty        <= '0;
            d_cost       <= '0;
            val_idx      <= '0;
            acc_eq       <= '0;
            acc_px       <= '0;
            for (int unsigned i = 0; i < N_STOCKS; i++) begin
                holding[i]    <= QTY_W'(INIT_SHARES);
                last_price[i] <= '0;
            end
        end else begin
            trade_valid  <= 1'b0;
            equity_valid <= 1'b0;
            in_ready     <= (state_n == IDLE);

            if (accept_c) begin
                r_id    <= data_in[ID_W+PRICE_W-1:PRICE_W];
                r_price <= data_in[PRICE_W-1:0];
                r_nb    <= pop3(buy_votes);
                r_ns    <= pop3(sell_votes);
            end

            if (state == CALC) begin
                d_trade <= trade_c;
                d_side  <= sell_c;
                d_qty   <= q_c;
                d_cost  <= cost_c;
                d_rej   <= reject_c;
            end

            if (state == EXEC) begin
                // price is tracked even when no trade is made
                last_price[r_id] <= r_price;
                if (d_rej) reject_cnt <= reject_cnt + 8'd1;
                if (d_trade) begin
                    trade_valid <= 1'b1;
                    trade_side  <= d_side;
                    trade_id    <= r_id;
                    trade_qty   <= d_qty;
                    trade_cost  <= d_cost;
                    if (d_side) begin
                        holding[r_id] <= holding[r_id] - d_qty;
                        cash          <= cash_sell_c;
                    end else begin
                        holding[r_id] <= holding[r_id] + d_qty;
                        cash          <= cash - CASH_W'(d_cost);
                    end
                end
                val_idx <= '0;
                acc_eq  <= '0;
                acc_px  <= '0;
            end

            if (state == VALUE) begin
                val_idx <= val_idx + ID_W'(1);
                acc_eq  <= eq_next_c;
                acc_px  <= px_next_c;
                if (last_c) begin
                    equity       <= eq_total_c;
                    pnl          <= $signed(pnl_c);
                    equity_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_kelly_portfolio.sv
// Directed bench for kelly_portfolio: a table of hand-computed transactions
// plus sequences for position exhaustion and reset in the middle of a transaction.
module tb_kelly_portfolio;

    logic               clk = 1'b0;
    logic               rst;
    logic               enable;
    logic [15:0]        data_in;
    logic [2:0]         buy_votes, sell_votes;
    logic               in_ready, trade_valid, trade_side, equity_valid;
    logic [1:0]         trade_id;
    logic [9:0]         trade_qty;
    logic [23:0]        trade_cost;
    logic [7:0]         reject_cnt;
    logic [23:0]        cash;
    logic [31:0]        equity;
    logic signed [31:0] pnl;

    kelly_portfolio dut (
        .clk(clk), .rst(rst), .enable(enable), .data_in(data_in),
        .buy_votes(buy_votes), .sell_votes(sell_votes), .in_ready(in_ready),
        .trade_valid(trade_valid), .trade_side(trade_side), .trade_id(trade_id),
        .trade_qty(trade_qty), .trade_cost(trade_cost), .reject_cnt(reject_cnt),
        .cash(cash), .equity(equity), .pnl(pnl), .equity_valid(equity_valid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  id;
        logic [13:0] price;
        logic [2:0]  bv, sv;
        bit          junk;
        bit          exp_trade;
        bit          exp_side;
        int          exp_qty, exp_cost, exp_cash, exp_rej, exp_eq, exp_pnl;
    } vec_t;

    // results of the last transaction
    bit          got_trade;
    int          tcyc, ecyc, ready_at_ecyc;
    logic        cap_side;
    logic [1:0]  cap_id;
    logic [9:0]  cap_qty;
    logic [23:0] cap_cost;

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) chk("ready_timeout", 0, 1);
    endtask

    // One transaction; optionally keeps enable high with other data while busy.
    task automatic run_txn(input logic [1:0] id, input logic [13:0] price,
                           input logic [2:0] bv, input logic [2:0] sv, input bit junk);
        got_trade = 1'b0; tcyc = -1; ecyc = -1; ready_at_ecyc = 0;
        wait_ready();
        enable = 1'b1; data_in = {id, price}; buy_votes = bv; sell_votes = sv;
        @(posedge clk); #1;
        if (junk) begin
            data_in = {~id, 14'd5}; buy_votes = 3'b111; sell_votes = 3'b000;
        end else begin
            enable = 1'b0;
        end
        chk("busy_ready_low", in_ready, 0);
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (k == 5) enable = 1'b0;
            if (trade_valid) begin
                got_trade = 1'b1; tcyc = k;
                cap_side = trade_side; cap_id = trade_id;
                cap_qty = trade_qty; cap_cost = trade_cost;
            end
            if (equity_valid) begin
                ecyc = k; ready_at_ecyc = int'(in_ready);
                break;
            end
        end
        enable = 1'b0;
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{2'd1, 14'd100,   3'b110, 3'b000, 1'b0, 1'b1, 1'b0, 20, 2000, 23000, 0, 35000,   0};
        vecs[1] = '{2'd1, 14'd150,   3'b000, 3'b011, 1'b0, 1'b1, 1'b1, 24, 3600, 26600, 0, 41000,   1000};
        vecs[2] = '{2'd2, 14'd16383, 3'b110, 3'b000, 1'b1, 1'b0, 1'b0, 0,  0,    26600, 1, 1679300, 1000};
        vecs[3] = '{2'd1, 14'd150,   3'b011, 3'b101, 1'b0, 1'b0, 1'b0, 0,  0,    26600, 1, 1679300, 1000};
        vecs[4] = '{2'd0, 14'd50,    3'b111, 3'b000, 1'b0, 1'b1, 1'b0, 20, 1000, 25600, 1, 1684300, 1000};
        vecs[5] = '{2'd1, 14'd200,   3'b001, 3'b111, 1'b0, 1'b1, 1'b1, 19, 3800, 29400, 1, 1689100, 800};
        vecs[6] = '{2'd0, 14'd60,    3'b000, 3'b001, 1'b0, 1'b0, 1'b0, 0,  0,    29400, 1, 1690300, 1000};

        rst = 1'b1; enable = 1'b0; data_in = '0; buy_votes = '0; sell_votes = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_trade_valid", trade_valid, 0);
        chk("rst_trade_qty", trade_qty, 0);
        chk("rst_cash", cash, 25000);
        chk("rst_equity", equity, 25000);
        chk("rst_pnl", longint'(pnl), 0);
        chk("rst_reject", reject_cnt, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_in_ready", in_ready, 1);
        chk("idle_equity_valid", equity_valid, 0);

        // Table of hand-computed transactions
        for (int i = 0; i < 7; i++) begin
            run_txn(vecs[i].id, vecs[i].price, vecs[i].bv, vecs[i].sv, vecs[i].junk);
            chk($sformatf("v%0d_trade", i), got_trade, vecs[i].exp_trade);
            if (vecs[i].exp_trade) begin
                chk($sformatf("v%0d_trade_lat", i), tcyc, 2);
                chk($sformatf("v%0d_side", i), cap_side, vecs[i].exp_side);
                chk($sformatf("v%0d_id", i), cap_id, vecs[i].id);
                chk($sformatf("v%0d_qty", i), cap_qty, vecs[i].exp_qty);
                chk($sformatf("v%0d_cost", i), cap_cost, vecs[i].exp_cost);
            end
            chk($sformatf("v%0d_eq_lat", i), ecyc, 6);
            chk($sformatf("v%0d_ready_back", i), ready_at_ecyc, 1);
            chk($sformatf("v%0d_cash", i), cash, vecs[i].exp_cash);
            chk($sformatf("v%0d_reject", i), reject_cnt, vecs[i].exp_rej);
            chk($sformatf("v%0d_equity", i), equity, vecs[i].exp_eq);
            chk($sformatf("v%0d_pnl", i), longint'(pnl), vecs[i].exp_pnl);
        end

        // Sell stock 3 down to zero, then one more sell must not trade
        begin
            int h = 100;
            int c = 29400;
            int q;
            int it = 0;
            while (h > 0 && it < 40) begin
                q = (h * 20) / 100;
                if (q == 0) q = 1;
                if (q > h) q = h;
                run_txn(2'd3, 14'd10, 3'b000, 3'b111, 1'b0);
                h -= q;
                c += q * 10;
                chk($sformatf("s%0d_trade", it), got_trade, 1);
                chk($sformatf("s%0d_side", it), cap_side, 1);
                chk($sformatf("s%0d_qty", it), cap_qty, q);
                chk($sformatf("s%0d_cost", it), cap_cost, q * 10);
                chk($sformatf("s%0d_cash", it), cash, c);
                it++;
            end
            run_txn(2'd3, 14'd10, 3'b000, 3'b111, 1'b0);
            chk("empty_sell_trade", got_trade, 0);
            chk("empty_sell_cash", cash, 30400);
            chk("empty_sell_eq_lat", ecyc, 6);
        end

        // Reset during VALUE aborts the transaction
        begin
            bit seen = 1'b0;
            wait_ready();
            enable = 1'b1; data_in = {2'd0, 14'd10}; buy_votes = 3'b111; sell_votes = 3'b000;
            @(posedge clk); #1;
            enable = 1'b0;
            repeat (4) @(posedge clk);
            #1;
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            chk("midrst_in_ready", in_ready, 1);
            chk("midrst_cash", cash, 25000);
            chk("midrst_equity", equity, 25000);
            chk("midrst_pnl", longint'(pnl), 0);
            chk("midrst_reject", reject_cnt, 0);
            chk("midrst_trade_valid", trade_valid, 0);
            for (int k = 0; k < 8; k++) begin
                if (equity_valid) seen = 1'b1;
                @(posedge clk); #1;
            end
            chk("midrst_no_equity_valid", seen, 0);
        end

        // Holdings back at 100 each: value each stock with no trade
        begin
            int exp_eq = 25000;
            for (int i = 0; i < 4; i++) begin
                run_txn(2'(i), 14'(10 * (i + 1)), 3'b000, 3'b000, 1'b0);
                exp_eq += 100 * 10 * (i + 1);
                chk($sformatf("post_rst%0d_trade", i), got_trade, 0);
                chk($sformatf("post_rst%0d_equity", i), equity, exp_eq);
                chk($sformatf("post_rst%0d_pnl", i), longint'(pnl), 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
